alu_cmd_sequencer: RTL
======================

// Module: alu_cmd_sequencer
// PURPOSE
//   Command front-end for the 4-bit ALU. Accepts {opA, opB, op} commands over valid/ready
//   and buffers them in a small FIFO. Issues one command at a time to the ALU through
//   registered operand/operation outputs, captures the ALU result and returns it over a
//   valid/ready response channel. Sits directly upstream (drives ALU inputs) and downstream
//   (consumes ALU result) of the combinational ALU.
// PARAMETERS
//   FIFO_DEPTH  4   command FIFO entries; power of 2, >= 2
//   CNT_W       16  width of the completed-command counter
// PORTS
//   clk            in   1      single clock, all state on rising edge
//   rst            in   1      synchronous, active-high reset
//   cmd_valid      in   1      command present
//   cmd_ready      out  1      FIFO can accept (= !full)
//   cmd_opa        in   4      operand A
//   cmd_opb        in   4      operand B
//   cmd_op         in   3      000 add, 001 sub, 010 and, 011 or, 100 mul, 101-111 illegal
//   alu_operandA   out  4      registered, to ALU operandA
//   alu_operandB   out  4      registered, to ALU operandB
//   alu_operation  out  3      registered, to ALU operation
//   alu_result     in   8      from ALU result (combinational from alu_* outputs)
//   rsp_valid      out  1      response held
//   rsp_ready      in   1      consumer takes response
//   rsp_result     out  8      captured alu_result
//   rsp_zero       out  1      (rsp_result == 8'h00), computed locally; ALU zeroFlag unused
//   rsp_illegal    out  1      issued op was 101-111
//   busy           out  1      FSM not IDLE or FIFO non-empty
//   done_count     out  CNT_W  responses completed (rsp handshakes), wraps at 2**CNT_W
// BEHAVIOUR
//   Reset: FIFO empty, FSM IDLE, alu_* = 0, rsp_valid/rsp_result/rsp_zero/rsp_illegal = 0,
//     done_count = 0, busy = 0. Any in-flight command or held response is discarded.
//   FIFO: push on cmd_valid & cmd_ready. cmd_ready = !full only (no same-cycle pop credit).
//     No bypass: a push into an empty FIFO is poppable the next cycle. Pointers wrap mod
//     FIFO_DEPTH; occupancy counter 0..FIFO_DEPTH distinguishes full from empty.
//   FSM states IDLE, ISSUE, HOLD:
//     IDLE:  FIFO non-empty -> pop head into alu_*, go ISSUE; else stay.
//     ISSUE: ALU settles this cycle; at edge capture rsp_result <= alu_result,
//            rsp_zero <= (alu_result == 0), rsp_illegal <= (alu_operation > 3'b100),
//            rsp_valid <= 1, go HOLD.
//     HOLD:  wait for rsp_ready. On handshake: rsp_valid <= 0, done_count++; if FIFO
//            non-empty pop next into alu_* and go ISSUE (same edge), else go IDLE.
//   alu_* hold the last issued command until the next pop (not cleared after capture).
//   Response fields are stable while rsp_valid = 1 and rsp_ready = 0.
//   Latency: command accepted at edge N into empty idle block -> popped at N+1,
//     rsp_valid = 1 after edge N+2. Sustained throughput with rsp_ready = 1: 1 rsp / 2 clk.
//   Width: rsp_result is exactly the 8-bit ALU result; sub wraps mod 256 (3-5 = 8'hFE),
//     mul max 15*15 = 8'hE1. Illegal ops: ALU returns 0 -> rsp_result 0, zero 1, illegal 1.
//   Order: responses in strict command-acceptance order; no command dropped unless rst.
// TESTING
//   Reset, then cmd {opa 3, opb 5, op 000} at edge N -> rsp_valid after N+2, result 8'h08, zero 0.
//   {3,5,001} -> 8'hFE; {15,15,100} -> 8'hE1; {4'hA,4'h5,010} -> 8'h00, zero 1, illegal 0.
//   op 3'b110 with {7,7} -> result 0, zero 1, illegal 1; done_count increments.
//   Hold rsp_ready = 0, push 5 cmds -> 4 in FIFO + 1 held, cmd_ready = 0 on the 6th;
//     release rsp_ready -> 5 responses in order, one per 2 clk, done_count = 5.
//   Assert rst while rsp_valid = 1 and FIFO = 2 -> next cycle rsp_valid 0, cmd_ready 1,
//     busy 0, done_count 0, alu_* = 0; no stale response emerges afterwards.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the 4-bit ALU: buffers {opA, opB, op} commands in a small FIFO,
// issues them one at a time through registered ALU inputs and returns each result over valid/ready.
module alu_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_opa,
  input  logic [3:0]       cmd_opb,
  input  logic [2:0]       cmd_op,
  output logic [3:0]       alu_operandA,
  output logic [3:0]       alu_operandB,
  output logic [2:0]       alu_operation,
  input  logic [7:0]       alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_result,
  output logic             rsp_zero,
  output logic             rsp_illegal,
  output logic             busy,
  output logic [CNT_W-1:0] done_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} stateT;

  typedef struct packed {
    logic [3:0] opA;
    logic [3:0] opB;
    logic [2:0] op;
  } cmdT;

  stateT            state;
  stateT            nextState;
  cmdT              fifoMem [FIFO_DEPTH];
  cmdT              headCmd;
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W:0]   occupancy;
  logic             fifoFull;
  logic             fifoEmpty;
  logic             push;
  logic             pop;
  logic             rspTaken;

  assign fifoFull  = (occupancy == (PTR_W+1)'(FIFO_DEPTH));
  assign fifoEmpty = (occupancy == '0);
  assign cmd_ready = !fifoFull;
  assign push      = cmd_valid && cmd_ready;
  assign headCmd   = fifoMem[rdPtr];
  assign rspTaken  = (state == HOLD) && rsp_valid && rsp_ready;
  assign busy      = (state != IDLE) || !fifoEmpty;

  // Storage needs no reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem[wrPtr] <= '{opA: cmd_opa, opB: cmd_opb, op: cmd_op};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      occupancy <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   occupancy <= occupancy + (PTR_W+1)'(1);
        2'b01:   occupancy <= occupancy - (PTR_W+1)'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // A pop happens from IDLE, or back-to-back from HOLD on the same edge as the handshake.
  always_comb begin
    nextState = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifoEmpty) begin
          pop       = 1'b1;
          nextState = ISSUE;
        end
      end
      ISSUE: begin
        nextState = HOLD;
      end
      HOLD: begin
        if (rsp_valid && rsp_ready) begin
          if (!fifoEmpty) begin
            pop       = 1'b1;
            nextState = ISSUE;
          end else begin
            nextState = IDLE;
          end
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      alu_operandA  <= '0;
      alu_operandB  <= '0;
      alu_operation <= '0;
      rsp_valid     <= 1'b0;
      rsp_result    <= '0;
      rsp_zero      <= 1'b0;
      rsp_illegal   <= 1'b0;
      done_count    <= '0;
    end else begin
      state <= nextState;
      if (pop) begin
        alu_operandA  <= headCmd.opA;
        alu_operandB  <= headCmd.opB;
        alu_operation <= headCmd.op;
      end
      // The ALU has had a full cycle to settle on the registered inputs.
      if (state == ISSUE) begin
        rsp_valid   <= 1'b1;
        rsp_result  <= alu_result;
        rsp_zero    <= (alu_result == 8'h00);
        rsp_illegal <= (alu_operation > 3'b100);
      end
      if (rspTaken) begin
        rsp_valid  <= 1'b0;
        done_count <= done_count + CNT_W'(1);
      end
    end
  end

endmodule
